fix_session_sequencer: RTL and testbench

- Session-level scheduler for the FIX transmit path. Accepts logon and logout requests and generates heartbeats from an internal timer.
- Arbitrates these requests onto the single shared bodylength/BCD conversion datapath. Drives its start, message-type and MsgSeqNum-length inputs and waits for its valid output.
- Presents the granted message descriptor (type, MsgSeqNum) to the downstream assembler through a valid/ready handshake.
- Owns the MsgSeqNum counter and the logged-in session state.

---
 rtl/fix_session_sequencer.sv | 137 +++++++++++++
 tb/tb_fix_session_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_session_sequencer.sv
// FIX session scheduler: queues logon/logout/heartbeat requests, drives the shared
// bodylength conversion datapath and hands the granted descriptor to the assembler.
module fix_session_sequencer #(
  parameter int         SEQ_WIDTH    = 32,
  parameter int         HB_INTERVAL  = 1000,
  parameter int         CONV_TIMEOUT = 64,
  parameter logic [3:0] LOGON_CODE   = 4'd1,
  parameter logic [3:0] LOGOUT_CODE  = 4'd2,
  parameter logic [3:0] HB_CODE      = 4'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 logon_req_i,
  input  logic                 logout_req_i,
  output logic                 bl_start_o,
  output logic [3:0]           bl_create_message_o,
  output logic [3:0]           bl_seqnum_len_o,
  input  logic                 bl_valid_i,
  output logic                 msg_valid_o,
  input  logic                 msg_ready_i,
  output logic [3:0]           msg_type_o,
  output logic [SEQ_WIDTH-1:0] msg_seq_num_o,
  output logic                 logged_in_o,
  output logic                 busy_o,
  output logic                 error_o
);

  localparam int HB_W = (HB_INTERVAL > 1) ? $clog2(HB_INTERVAL) : 1;
  localparam int TO_W = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_ABORT, S_PRESENT} state_t;

  state_t               state_reg, state_next;
  logic                 logon_pend_reg, logout_pend_reg, hb_pend_reg;
  logic [3:0]           type_reg;
  logic [SEQ_WIDTH-1:0] seq_reg;
  logic                 logged_in_reg;
  logic [HB_W-1:0]      hb_cnt_reg;
  logic [TO_W-1:0]      to_cnt_reg;

  logic       evaluate, logon_ok, logout_ok, hb_ok, grant, accept, hb_fire;
  logic       clear_logon, clear_logout, clear_hb;
  logic [3:0] grant_code;

  // Every evaluated flag is either granted or dropped, except a heartbeat
  // that loses to a valid logout: it stays pending.
  always_comb begin
    evaluate     = (state_reg == S_IDLE) && enable_i;
    logout_ok    = logout_pend_reg && logged_in_reg;
    logon_ok     = logon_pend_reg && !logged_in_reg;
    hb_ok        = hb_pend_reg && logged_in_reg;
    grant        = evaluate && (logout_ok || logon_ok || hb_ok);
    grant_code   = logout_ok ? LOGOUT_CODE : (logon_ok ? LOGON_CODE : HB_CODE);
    clear_logout = evaluate && logout_pend_reg;
    clear_logon  = evaluate && logon_pend_reg;
    clear_hb     = evaluate && hb_pend_reg && !logout_ok;
    accept       = (state_reg == S_PRESENT) && msg_ready_i;
    hb_fire      = logged_in_reg && !accept && (hb_cnt_reg == HB_W'(HB_INTERVAL - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (grant) state_next = S_START;
      S_START:   state_next = S_WAIT;
      S_WAIT: begin
        if (bl_valid_i)                                 state_next = S_PRESENT;
        else if (to_cnt_reg == TO_W'(CONV_TIMEOUT - 1)) state_next = S_ABORT;
      end
      S_ABORT:   state_next = S_IDLE;
      S_PRESENT: if (msg_ready_i) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bl_start_o          = (state_reg == S_START);
    error_o             = (state_reg == S_ABORT);
    msg_valid_o         = (state_reg == S_PRESENT);
    busy_o              = (state_reg != S_IDLE);
    bl_create_message_o = (state_reg == S_IDLE) ? 4'd0 : type_reg;
    msg_type_o          = (state_reg == S_PRESENT) ? type_reg : 4'd0;
    msg_seq_num_o       = seq_reg;
    logged_in_o         = logged_in_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      logon_pend_reg  <= 1'b0;
      logout_pend_reg <= 1'b0;
      hb_pend_reg     <= 1'b0;
      type_reg        <= 4'd0;
      seq_reg         <= SEQ_WIDTH'(1);
      logged_in_reg   <= 1'b0;
      hb_cnt_reg      <= '0;
      to_cnt_reg      <= '0;
    end else begin
      logon_pend_reg  <= clear_logon  ? 1'b0 : (logon_pend_reg  | logon_req_i);
      logout_pend_reg <= clear_logout ? 1'b0 : (logout_pend_reg | logout_req_i);
      hb_pend_reg     <= clear_hb     ? 1'b0 : (hb_pend_reg     | hb_fire);
      if (grant) type_reg <= grant_code;
      to_cnt_reg <= (state_reg == S_WAIT) ? to_cnt_reg + TO_W'(1) : '0;
      if (accept || !logged_in_reg || hb_fire) hb_cnt_reg <= '0;
      else                                     hb_cnt_reg <= hb_cnt_reg + HB_W'(1);
      if (accept) begin
        // MsgSeqNum 0 is not a legal FIX value, so the counter skips it on wrap.
        seq_reg <= (&seq_reg) ? SEQ_WIDTH'(1) : seq_reg + SEQ_WIDTH'(1);
        if (type_reg == LOGON_CODE)       logged_in_reg <= 1'b1;
        else if (type_reg == LOGOUT_CODE) logged_in_reg <= 1'b0;
      end
    end
  end

  // Decimal digit count: one plus the number of powers of ten not exceeding seq.
  logic [63:0] seq_wide;
  logic [9:1]  digit_ge;
  assign seq_wide = 64'(seq_reg);

  generate
    for (genvar gi = 1; gi <= 9; gi++) begin : g_digit
      localparam logic [63:0] THRESH = 64'(10 ** gi);
      assign digit_ge[gi] = (seq_wide >= THRESH);
    end
  endgenerate

  always_comb begin
    bl_seqnum_len_o = 4'd1;
    for (int i = 1; i <= 9; i++) bl_seqnum_len_o = bl_seqnum_len_o + {3'b000, digit_ge[i]};
  end

endmodule

// File: tb/tb_fix_session_sequencer.sv
// Randomized session traffic checked against a transaction-level model of
// session state, MsgSeqNum and heartbeat timing.
module tb_fix_session_sequencer;
  localparam int SW = 8;
  localparam int HB = 20;
  localparam int CT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable_i = 1'b0;
  logic          logon_req_i = 1'b0;
  logic          logout_req_i = 1'b0;
  logic          bl_valid_i = 1'b0;
  logic          msg_ready_i = 1'b0;
  logic          bl_start_o;
  logic [3:0]    bl_create_message_o;
  logic [3:0]    bl_seqnum_len_o;
  logic          msg_valid_o;
  logic [3:0]    msg_type_o;
  logic [SW-1:0] msg_seq_num_o;
  logic          logged_in_o;
  logic          busy_o;
  logic          error_o;

  fix_session_sequencer #(.SEQ_WIDTH(SW), .HB_INTERVAL(HB), .CONV_TIMEOUT(CT)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .logon_req_i(logon_req_i),
    .logout_req_i(logout_req_i), .bl_start_o(bl_start_o),
    .bl_create_message_o(bl_create_message_o), .bl_seqnum_len_o(bl_seqnum_len_o),
    .bl_valid_i(bl_valid_i), .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i),
    .msg_type_o(msg_type_o), .msg_seq_num_o(msg_seq_num_o), .logged_in_o(logged_in_o),
    .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, accept_cyc = 0, accepts = 0, wraps = 0;
  int m_seq = 1;
  bit m_li = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int digits(input int v);
    int d = 1;
    int x = v;
    while (x >= 10) begin
      x = x / 10;
      d++;
    end
    return d;
  endfunction

  task automatic pulse(input bit lon, input bit lout);
    logon_req_i  = lon;
    logout_req_i = lout;
    step();
    logon_req_i  = 1'b0;
    logout_req_i = 1'b0;
  endtask

  task automatic wait_start(input int maxc, output bit found);
    found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      step();
      if (bl_start_o === 1'b1) found = 1'b1;
    end
  endtask

  task automatic expect_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("no_start", bl_start_o, 0);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_start", bl_start_o, 0);
    chk("rst_create", bl_create_message_o, 0);
    chk("rst_len", bl_seqnum_len_o, 1);
    chk("rst_valid", msg_valid_o, 0);
    chk("rst_type", msg_type_o, 0);
    chk("rst_seq", msg_seq_num_o, 1);
    chk("rst_logged_in", logged_in_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_error", error_o, 0);
  endtask

  task automatic run_txn(input logic [3:0] exp_type, input bit to);
    bit found;
    int cw, lat, rd;
    wait_start(HB + 8, found);
    chk("start_seen", found, 1);
    if (!found) return;
    if (exp_type == 4'd3) chk("hb_delay", cyc - accept_cyc, HB + 1);
    chk("start_type", bl_create_message_o, exp_type);
    chk("start_len", bl_seqnum_len_o, digits(m_seq));
    chk("start_busy", busy_o, 1);
    step();
    cw = cyc;
    chk("start_one_cycle", bl_start_o, 0);
    chk("hold_type", bl_create_message_o, exp_type);
    if (to) begin
      found = 1'b0;
      for (int i = 0; i < CT + 4 && !found; i++) begin
        step();
        if (error_o === 1'b1) found = 1'b1;
      end
      chk("error_seen", found, 1);
      chk("error_delay", cyc - cw, CT);
      chk("abort_seq", msg_seq_num_o, m_seq);
      step();
      chk("error_one_cycle", error_o, 0);
      chk("abort_idle", busy_o, 0);
      chk("abort_no_valid", msg_valid_o, 0);
      chk("abort_logged_in", logged_in_o, m_li);
      $display("txn type=%0d seq=%0d timeout", exp_type, m_seq);
      return;
    end
    lat = $urandom_range(0, 6);
    for (int i = 0; i < lat; i++) begin
      step();
      chk("wait_no_valid", msg_valid_o, 0);
    end
    bl_valid_i = 1'b1;
    step();
    bl_valid_i = 1'b0;
    chk("msg_valid", msg_valid_o, 1);
    chk("msg_type", msg_type_o, exp_type);
    chk("msg_seq", msg_seq_num_o, m_seq);
    chk("present_create", bl_create_message_o, exp_type);
    rd = $urandom_range(0, 4);
    for (int i = 0; i < rd; i++) begin
      step();
      chk("bp_valid", msg_valid_o, 1);
      chk("bp_type", msg_type_o, exp_type);
      chk("bp_seq", msg_seq_num_o, m_seq);
      chk("bp_no_start", bl_start_o, 0);
    end
    msg_ready_i = 1'b1;
    step();
    msg_ready_i = 1'b0;
    accept_cyc = cyc;
    accepts++;
    if (m_seq == (1 << SW) - 1) begin
      m_seq = 1;
      wraps++;
    end else begin
      m_seq = m_seq + 1;
    end
    if (exp_type == 4'd1) m_li = 1'b1;
    if (exp_type == 4'd2) m_li = 1'b0;
    chk("valid_drop", msg_valid_o, 0);
    chk("seq_after", msg_seq_num_o, m_seq);
    chk("len_after", bl_seqnum_len_o, digits(m_seq));
    chk("logged_in", logged_in_o, m_li);
    $display("txn type=%0d lat=%0d ready_delay=%0d next_seq=%0d logged_in=%0d",
             exp_type, lat, rd, m_seq, m_li);
  endtask

  initial begin
    bit found;
    int r;
    repeat (3) step();
    rst = 1'b0;
    check_reset_outputs();
    enable_i = 1'b1;

    for (int iter = 0; iter < 2000 && accepts < 300; iter++) begin
      r = $urandom_range(0, 7);
      if (!m_li) begin
        if (r == 0) begin
          enable_i = 1'b0;
          pulse(1'b1, 1'b0);
          expect_quiet(5);
          chk("disabled_idle", busy_o, 0);
          enable_i = 1'b1;
          run_txn(4'd1, 1'b0);
        end else if (r == 1) begin
          pulse(1'b1, 1'b0);
          run_txn(4'd1, 1'b1);
        end else begin
          pulse(1'b1, 1'b0);
          run_txn(4'd1, 1'b0);
        end
      end else begin
        if (r == 0) begin
          pulse(1'b1, 1'b0);
          expect_quiet(5);
          chk("dropped_logon_state", logged_in_o, 1);
          run_txn(4'd3, 1'b0);
        end else if (r == 1 || r == 5) begin
          run_txn(4'd3, 1'b0);
        end else if (r == 2) begin
          pulse(1'b1, 1'b1);
          run_txn(4'd2, 1'b0);
          expect_quiet(6);
          chk("priority_logged_out", logged_in_o, 0);
        end else begin
          pulse(1'b0, 1'b1);
          run_txn(4'd2, 1'b0);
        end
      end
    end
    chk("seq_wrapped", wraps > 0, 1);

    // Reset in the middle of a conversion wait.
    pulse(1'b1, 1'b0);
    wait_start(8, found);
    chk("rst_test_start", found, 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_seq = 1;
    m_li = 1'b0;
    check_reset_outputs();
    bl_valid_i = 1'b1;
    step();
    bl_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("late_valid_ignored", msg_valid_o, 0);
      chk("late_valid_idle", busy_o, 0);
    end
    $display("txn reset mid-wait seq=%0d", msg_seq_num_o);
    pulse(1'b1, 1'b0);
    run_txn(4'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
